// File: rtl/ro_puf_pkg.sv
// Shared types for the ring-oscillator PUF measurement controller.
// Holds the count width and the controller FSM state encoding.
package ro_puf_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_e;

endpackage

// File: rtl/ro_count_compare.sv
// Combinational compare of two RO counts: a > b, a == b and |a - b|.
// Ports: a, b (COUNT_W) in; gt, eq, abs_diff out.
module ro_count_compare
    import ro_puf_pkg::*;
(
    input  logic [COUNT_W-1:0] a,
    input  logic [COUNT_W-1:0] b,
    output logic               gt,
    output logic               eq,
    output logic [COUNT_W-1:0] abs_diff
);

    always_comb begin
        gt       = a > b;
        eq       = a == b;
        abs_diff = gt ? (a - b) : (b - a);
    end

endmodule

// File: rtl/ro_pair_measure_ctrl.sv
// Sequences one RO-pair measurement: clear, run, settle, capture, report.
// Ports: clk, reset, start in; ro0_count/ro1_count in; ro_enable,
// ro_reset_n, busy, done, response, tie, diff_mag out (all registered).
module ro_pair_measure_ctrl
    import ro_puf_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES  = 2,
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] ro0_count,
    input  logic [COUNT_W-1:0] ro1_count,
    output logic               ro_enable,
    output logic               ro_reset_n,
    output logic               busy,
    output logic               done,
    output logic               response,
    output logic               tie,
    output logic [COUNT_W-1:0] diff_mag
);

    // Phase counter is loaded with (duration - 1) and counts down to zero.
    localparam logic [15:0] CLR_LD = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] WIN_LD = 16'(WINDOW_CYCLES - 1);
    localparam logic [15:0] SET_LD = 16'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [15:0]        phase_q, phase_d;
    logic [COUNT_W-1:0] cap0_q, cap0_d;
    logic [COUNT_W-1:0] cap1_q, cap1_d;
    logic               resp_q, resp_d;
    logic               tie_q, tie_d;
    logic [COUNT_W-1:0] diff_q, diff_d;
    logic               en_q, en_d;
    logic               rstn_q, rstn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cmp_gt;
    logic               cmp_eq;
    logic [COUNT_W-1:0] cmp_diff;

    ro_count_compare u_cmp (
        .a        (cap0_q),
        .b        (cap1_q),
        .gt       (cmp_gt),
        .eq       (cmp_eq),
        .abs_diff (cmp_diff)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        diff_d  = diff_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    phase_d = CLR_LD;
                end
            end
            S_CLEAR: begin
                if (phase_q == '0) begin
                    state_d = S_RUN;
                    phase_d = WIN_LD;
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            S_RUN: begin
                if (phase_q == '0) begin
                    state_d = S_SETTLE;
                    phase_d = SET_LD;
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            S_SETTLE: begin
                if (phase_q == '0) begin
                    // Oscillators have been off for the settle time,
                    // so the counts are stable and safe to sample.
                    state_d = S_CAPTURE;
                    phase_d = '0;
                    cap0_d  = ro0_count;
                    cap1_d  = ro1_count;
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_DONE;
                phase_d = '0;
                resp_d  = cmp_gt;
                tie_d   = cmp_eq;
                diff_d  = cmp_diff;
            end
            S_DONE: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
        // Outputs decode the next state so they are registered yet
        // line up with the state they describe.
        en_d   = state_d == S_RUN;
        rstn_d = state_d != S_CLEAR;
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cap0_q  <= '0;
            cap1_q  <= '0;
            resp_q  <= 1'b0;
            tie_q   <= 1'b0;
            diff_q  <= '0;
            en_q    <= 1'b0;
            rstn_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cap0_q  <= cap0_d;
            cap1_q  <= cap1_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            diff_q  <= diff_d;
            en_q    <= en_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ro_enable  = en_q;
    assign ro_reset_n = rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign response   = resp_q;
    assign tie        = tie_q;
    assign diff_mag   = diff_q;

endmodule

// File: tb/tb_ro_pair_measure_ctrl.sv
// Testbench for ro_pair_measure_ctrl with CLEAR=2, WINDOW=8, SETTLE=4.
// Table vectors, randomized vectors and a mid-run reset sequence.
module tb_ro_pair_measure_ctrl;

    localparam int C = 2;
    localparam int W = 8;
    localparam int S = 4;
    localparam int L = C + W + S + 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] ro0_count;
    logic [15:0] ro1_count;
    logic        ro_enable;
    logic        ro_reset_n;
    logic        busy;
    logic        done;
    logic        response;
    logic        tie;
    logic [15:0] diff_mag;

    int checks = 0;
    int errors = 0;

    logic        prev_resp = 1'b0;
    logic        prev_tie  = 1'b0;
    logic [15:0] prev_diff = 16'd0;

    typedef struct {
        logic [15:0] ro0;
        logic [15:0] ro1;
        logic        resp;
        logic        tie;
        logic [15:0] diff;
        bit          extra;
    } vec_t;

    vec_t vecs[5];

    ro_pair_measure_ctrl #(
        .CLEAR_CYCLES  (C),
        .WINDOW_CYCLES (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ro0_count  (ro0_count),
        .ro1_count  (ro1_count),
        .ro_enable  (ro_enable),
        .ro_reset_n (ro_reset_n),
        .busy       (busy),
        .done       (done),
        .response   (response),
        .tie        (tie),
        .diff_mag   (diff_mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: comparison of two unsigned counts in plain arithmetic.
    function automatic void model(input int a, input int b,
                                  output logic r, output logic t,
                                  output logic [15:0] d);
        r = a > b;
        t = a == b;
        d = 16'((a > b) ? a - b : b - a);
    endfunction

    task automatic measure(input logic [15:0] a, input logic [15:0] b,
                           input logic er, input logic et,
                           input logic [15:0] ed, input bit extra);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rstn", ro_reset_n, 1);
        start     = 1'b1;
        ro0_count = 16'($urandom);
        ro1_count = 16'($urandom);
        for (int c = 1; c <= L + 2; c++) begin
            @(negedge clk);
            chk("ro_reset_n", ro_reset_n, (c >= 1 && c <= C) ? 0 : 1);
            chk("ro_enable", ro_enable, (c >= C + 1 && c <= C + W) ? 1 : 0);
            chk("busy", busy, (c >= 1 && c <= L) ? 1 : 0);
            chk("done", done, (c == L) ? 1 : 0);
            if (c < L) begin
                chk("held_resp", response, prev_resp);
                chk("held_tie", tie, prev_tie);
                chk("held_diff", diff_mag, prev_diff);
            end else begin
                chk("response", response, er);
                chk("tie", tie, et);
                chk("diff_mag", diff_mag, ed);
            end
            start = extra && (c == 5 || c == 12);
            if (c >= C + W + 1 && c <= L - 1) begin
                ro0_count = a;
                ro1_count = b;
            end else begin
                ro0_count = 16'($urandom);
                ro1_count = 16'($urandom);
            end
        end
        start     = 1'b0;
        prev_resp = er;
        prev_tie  = et;
        prev_diff = ed;
    endtask

    initial begin
        logic        r;
        logic        t;
        logic [15:0] d;
        logic [15:0] a;
        logic [15:0] b;

        vecs[0] = '{16'd1200, 16'd1100, 1'b1, 1'b0, 16'd100, 1'b1};
        vecs[1] = '{16'd500, 16'd731, 1'b0, 1'b0, 16'd231, 1'b0};
        vecs[2] = '{16'd4096, 16'd4096, 1'b0, 1'b1, 16'd0, 1'b0};
        vecs[3] = '{16'd65535, 16'd0, 1'b1, 1'b0, 16'd65535, 1'b0};
        vecs[4] = '{16'd0, 16'd65535, 1'b0, 1'b0, 16'd65535, 1'b1};

        reset     = 1'b1;
        start     = 1'b0;
        ro0_count = '0;
        ro1_count = '0;
        #1;
        chk("rst_enable", ro_enable, 0);
        chk("rst_rstn", ro_reset_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", response, 0);
        chk("rst_tie", tie, 0);
        chk("rst_diff", diff_mag, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rstn", ro_reset_n, 1);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 5; i++)
            measure(vecs[i].ro0, vecs[i].ro1, vecs[i].resp,
                    vecs[i].tie, vecs[i].diff, vecs[i].extra);

        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = (i == 3) ? a : 16'($urandom);
            model(int'(a), int'(b), r, t, d);
            measure(a, b, r, t, d, ($urandom_range(0, 1) == 1));
        end

        // Reset during the sixth RUN cycle.
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= C + 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_abort_enable", ro_enable, 1);
        reset = 1'b1;
        #1;
        chk("abort_enable", ro_enable, 0);
        chk("abort_rstn", ro_reset_n, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_resp", response, 0);
        chk("abort_diff", diff_mag, 0);
        @(negedge clk);
        reset     = 1'b0;
        prev_resp = 1'b0;
        prev_tie  = 1'b0;
        prev_diff = 16'd0;
        @(negedge clk);
        chk("abort_post_rstn", ro_reset_n, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        measure(16'd300, 16'd299, 1'b1, 1'b0, 16'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_pair_measure_ctrl.md
RO_PAIR_MEASURE_CTRL -- requirements
Module: ro_pair_measure_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 2: cycles counters held in reset before each measurement (1..255).
REQ-002 SHALL have parameter WINDOW_CYCLES, default 1000: cycles the RO pair is enabled (1..65535).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4: cycles after disable before counts are sampled (2..255).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one measurement; sampled only in IDLE.
REQ-007 ro0_count  input  16  RO0 counter value from the RO pair counter block.
REQ-008 ro1_count  input  16  RO1 counter value from the RO pair counter block.
REQ-009 ro_enable  output  1  enable to both ring oscillators.
REQ-010 ro_reset_n  output  1  active-low clear to both RO counters.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-013 response  output  1  PUF bit: 1 iff captured ro0 > ro1.
REQ-014 tie  output  1  1 iff captured ro0 == ro1.
REQ-015 diff_mag  output  16  |ro0 - ro1| of captured counts.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE.
REQ-017 IDLE -> CLEAR when start=1; start SHALL be ignored in all other states.
REQ-018 CLEAR SHALL last exactly CLEAR_CYCLES cycles with ro_reset_n=0, ro_enable=0; then -> RUN.
REQ-019 RUN SHALL last exactly WINDOW_CYCLES cycles with ro_reset_n=1, ro_enable=1; then -> SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles with ro_enable=0, ro_reset_n=1; then -> CAPTURE.
REQ-021 CAPTURE SHALL register ro0_count and ro1_count (counts are quiescent, so no synchroniser is required); then -> DONE.
REQ-022 DONE SHALL assert done for one cycle with response/tie/diff_mag computed from captured counts; then -> IDLE.
REQ-023 Latency: start sampled in cycle 0 -> done high in cycle CLEAR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+2.
REQ-024 response, tie, diff_mag SHALL hold their value until the next DONE; a tie SHALL give response=0.
REQ-025 diff_mag SHALL be the unsigned 16-bit magnitude; no wrap compensation (counter wrap is the integrator's concern via WINDOW_CYCLES).
REQ-026 A single 16-bit phase counter SHALL time CLEAR/RUN/SETTLE and be reloaded on every state entry.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 Reset SHALL force state IDLE, ro_enable=0, ro_reset_n=0, busy=0, done=0, response=0, tie=0, diff_mag=0, phase counter=0.
REQ-029 ro_reset_n SHALL go 1 on the first clock edge after reset deasserts and stay 1 in IDLE.
REQ-030 Reset asserted mid-measurement SHALL abort immediately with no done pulse; previous results cleared.

Structure
REQ-031 Shared package ro_puf_pkg SHALL hold the FSM state enum and COUNT_W=16.
REQ-032 Sub-module ro_count_compare (combinational: gt, eq, abs diff of two COUNT_W values) SHALL be instantiated once.

Verification (CLEAR=2, WINDOW=8, SETTLE=4; latency 16)
REQ-033 Reset, start pulse; model ro0=1200, ro1=1100 -> done in cycle 16, response=1, tie=0, diff_mag=100.
REQ-034 ro0=500, ro1=731 -> response=0, tie=0, diff_mag=231.
REQ-035 ro0=ro1=4096 -> response=0, tie=1, diff_mag=0.
REQ-036 Check ro_reset_n=0 exactly cycles 1-2, ro_enable=1 exactly cycles 3-10, busy high cycles 1-16; start pulses in cycles 5 and 12 are ignored, giving exactly one done.
REQ-037 Assert reset in cycle 6 of RUN -> ro_enable=0, ro_reset_n=0, busy=0 immediately; no done; a fresh start afterwards completes normally.
REQ-038 ro0=65535, ro1=0 -> response=1, diff_mag=65535; result held stable until the next DONE.
